// File: rtl/flit_demux_1to4.sv
// rtl/flit_demux_1to4.sv - 1-to-4 flit distributor with a small FIFO per output
//
// Steers each accepted input flit to one of four output FIFOs chosen by in_sel.
// Each output drains independently, so a stalled consumer only holds up the
// flits addressed to it.
//
// Optional feature macro: DEMUX_PKT_LOCK_EN
//   When defined, a two-state lock FSM keeps every packet, from its first flit
//   through the flit with in_last=1, on the output chosen by its first flit.
//   When undefined, in_last is ignored and each flit routes on its own in_sel.
//
// Parameters:
//   DATA_W      flit width in bits
//   FIFO_DEPTH  entries per output FIFO (power of two, >= 2)
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_data    input flit
//   in_sel     destination output index 0..3
//   in_last    tail-flit marker (used only with DEMUX_PKT_LOCK_EN)
//   in_valid   input flit valid
//   in_ready   input can accept (never depends on in_valid)
//   out_data   slice i = [i*DATA_W +: DATA_W] is the head flit of FIFO i
//   out_valid  bit i: FIFO i non-empty
//   out_ready  bit i: consumer i accepts the head flit

module flit_demux_1to4 #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [1:0]          in_sel,
    input  logic                in_last,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [4*DATA_W-1:0] out_data,
    output logic [3:0]          out_valid,
    input  logic [3:0]          out_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    // Per-output FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem    [4][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr [4];
    logic [PTR_W-1:0]  rd_ptr [4];
    logic [CNT_W-1:0]  count  [4];

    logic [3:0] full;
    logic [3:0] empty;
    logic [3:0] push;
    logic [3:0] pop;
    logic [1:0] route;
    logic       accept;

    always_comb begin
        full  = '0;
        empty = '0;
        for (int i = 0; i < 4; i++) begin
            full[i]  = (count[i] == FULL_CNT);
            empty[i] = (count[i] == '0);
        end
    end

`ifdef DEMUX_PKT_LOCK_EN
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] lock_sel;
    logic [1:0] lock_sel_next;

    // Inside a packet the route is pinned to the output of its first flit.
    assign route = (state == LOCKED) ? lock_sel : in_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lock_sel <= 2'd0;
        end else begin
            state    <= state_next;
            lock_sel <= lock_sel_next;
        end
    end

    always_comb begin
        state_next    = state;
        lock_sel_next = lock_sel;
        case (state)
            IDLE: begin
                // A single-flit packet (in_last=1) never enters LOCKED.
                if (accept && !in_last) begin
                    state_next    = LOCKED;
                    lock_sel_next = in_sel;
                end
            end
            LOCKED: begin
                if (accept && in_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
`else
    logic unused_last;

    assign route       = in_sel;
    assign unused_last = in_last;
`endif

    // A full FIFO refuses input even if it pops this cycle: in_ready looks
    // only at the current count, which keeps it free of out_ready paths.
    assign in_ready  = !full[route];
    assign accept    = in_valid && in_ready;
    assign push      = accept ? (4'b0001 << route) : 4'b0000;
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;

    // Head entries come straight from registered storage: no bypass from
    // in_data, so an accepted flit shows up one cycle later at the earliest.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < 4; i++) begin
            out_data[i*DATA_W +: DATA_W] = mem[i][rd_ptr[i]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
                for (int j = 0; j < FIFO_DEPTH; j++) begin
                    mem[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= in_data;
                    wr_ptr[i]         <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                // Simultaneous push and pop leaves the count unchanged.
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
        end
    end

endmodule

// File: tb/tb_flit_demux_1to4.sv
// tb/tb_flit_demux_1to4.sv - directed self-checking bench for flit_demux_1to4

module tb_flit_demux_1to4;

    logic         clk;
    logic         rst_n;
    logic [31:0]  in_data;
    logic [1:0]   in_sel;
    logic         in_last;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;

    int tests;
    int fails;

    flit_demux_1to4 #(.DATA_W(32), .FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] slice(input logic [127:0] d, input int p);
        return d[p*32 +: 32];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        out_ready = '0;
        step();
        step();
        tests++;
        if (out_valid !== 4'b0000) begin
            fails++;
            $display("FAIL reset_out_valid got=%b exp=0000", out_valid);
        end
        tests++;
        if (out_data !== 128'd0) begin
            fails++;
            $display("FAIL reset_out_data got=%h exp=0", out_data);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        in_valid = 1'b1;
        in_sel   = 2'd2;
        in_data  = 32'hA5A5_0001;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL single_in_ready got=%b exp=1", in_ready);
        end
        tests++;
        if (out_valid !== 4'b0000) begin
            fails++;
            $display("FAIL single_no_bypass got=%b exp=0000", out_valid);
        end
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 4'b0100) begin
            fails++;
            $display("FAIL single_out_valid got=%b exp=0100", out_valid);
        end
        tests++;
        if (slice(out_data, 2) !== 32'hA5A5_0001) begin
            fails++;
            $display("FAIL single_slice2 got=%h exp=a5a50001", slice(out_data, 2));
        end
        tests++;
        if (slice(out_data, 0) !== 32'd0 || slice(out_data, 1) !== 32'd0 || slice(out_data, 3) !== 32'd0) begin
            fails++;
            $display("FAIL single_other_slices got=%h exp=zero in slices 0,1,3", out_data);
        end
        out_ready = 4'b0100;
        step();
        out_ready = 4'b0000;
        tests++;
        if (out_valid !== 4'b0000) begin
            fails++;
            $display("FAIL single_drain got=%b exp=0000", out_valid);
        end
    endtask

    task automatic test_fill();
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 32'h11;
        step();
        in_data = 32'h12;
        step();
        in_valid = 1'b0;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL fill_full_sel1 got=%b exp=0", in_ready);
        end
        in_sel = 2'd3;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL fill_free_sel3 got=%b exp=1", in_ready);
        end
        in_sel    = 2'd1;
        in_valid  = 1'b1;
        in_data   = 32'h13;
        out_ready = 4'b0010;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL fill_no_passthrough got=%b exp=0", in_ready);
        end
        tests++;
        if (slice(out_data, 1) !== 32'h11 || out_valid !== 4'b0010) begin
            fails++;
            $display("FAIL fill_head0 got=%h/%b exp=11/0010", slice(out_data, 1), out_valid);
        end
        step();
        in_valid = 1'b0;
        tests++;
        if (slice(out_data, 1) !== 32'h12 || out_valid !== 4'b0010) begin
            fails++;
            $display("FAIL fill_head1 got=%h/%b exp=12/0010", slice(out_data, 1), out_valid);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL fill_resume got=%b exp=1", in_ready);
        end
        step();
        out_ready = 4'b0000;
        tests++;
        if (out_valid !== 4'b0000) begin
            fails++;
            $display("FAIL fill_drained got=%b exp=0000", out_valid);
        end
    endtask

    task automatic test_stream();
        out_ready = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_sel   = 2'(k % 4);
            in_data  = 32'h20 + 32'(k);
            #1;
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL stream_in_ready k=%0d got=%b exp=1", k, in_ready);
            end
            step();
            tests++;
            if (out_valid !== (4'b0001 << (k % 4)) || slice(out_data, k % 4) !== 32'h20 + 32'(k)) begin
                fails++;
                $display("FAIL stream_out k=%0d got=%b/%h exp=%b/%h", k, out_valid,
                         slice(out_data, k % 4), 4'b0001 << (k % 4), 32'h20 + 32'(k));
            end
        end
        in_valid = 1'b0;
        step();
        out_ready = 4'b0000;
        tests++;
        if (out_valid !== 4'b0000) begin
            fails++;
            $display("FAIL stream_drained got=%b exp=0000", out_valid);
        end
    endtask

    task automatic test_push_pop();
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        in_data   = 32'h30;
        step();
        tests++;
        if (out_valid !== 4'b0001 || slice(out_data, 0) !== 32'h30) begin
            fails++;
            $display("FAIL pushpop_held got=%b/%h exp=0001/30", out_valid, slice(out_data, 0));
        end
        in_data   = 32'h31;
        out_ready = 4'b0001;
        step();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        tests++;
        if (out_valid !== 4'b0001 || slice(out_data, 0) !== 32'h31) begin
            fails++;
            $display("FAIL pushpop_head got=%b/%h exp=0001/31", out_valid, slice(out_data, 0));
        end
        out_ready = 4'b0001;
        step();
        out_ready = 4'b0000;
        tests++;
        if (out_valid !== 4'b0000) begin
            fails++;
            $display("FAIL pushpop_count_one got=%b exp=0000", out_valid);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        in_data   = 32'h40;
        step();
        in_data = 32'h41;
        step();
        in_sel  = 2'd1;
        in_data = 32'h42;
        step();
        in_valid = 1'b0;
        in_sel   = 2'd0;
        #1;
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 4'b0011) begin
            fails++;
            $display("FAIL areset_before got=%b/%b exp=0/0011", in_ready, out_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 4'b0000 || in_ready !== 1'b1 || out_data !== 128'd0) begin
            fails++;
            $display("FAIL areset_immediate got=%b/%b/%h exp=0000/1/0", out_valid, in_ready, out_data);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_lock();
        logic [1:0]  sels  [4];
        logic        lasts [4];
        int          exp_port [4];
        sels  = '{2'd0, 2'd2, 2'd3, 2'd2};
        lasts = '{1'b0, 1'b0, 1'b1, 1'b1};
`ifdef DEMUX_PKT_LOCK_EN
        exp_port = '{0, 0, 0, 2};
`else
        exp_port = '{0, 2, 3, 2};
`endif
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_sel   = sels[k];
            in_last  = lasts[k];
            in_data  = 32'h50 + 32'(k);
            #1;
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL lock_in_ready k=%0d got=%b exp=1", k, in_ready);
            end
            step();
            tests++;
            if (out_valid !== (4'b0001 << exp_port[k]) || slice(out_data, exp_port[k]) !== 32'h50 + 32'(k)) begin
                fails++;
                $display("FAIL lock_route k=%0d got=%b/%h exp=%b/%h", k, out_valid,
                         slice(out_data, exp_port[k]), 4'b0001 << exp_port[k], 32'h50 + 32'(k));
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        out_ready = 4'b0000;
        tests++;
        if (out_valid !== 4'b0000) begin
            fails++;
            $display("FAIL lock_drained got=%b exp=0000", out_valid);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_push_pop();
        test_async_reset();
        test_lock();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/flit_demux_1to4.md
Name: flit_demux_1to4

Overview:
- 1-to-4 flit distributor: the demultiplexing counterpart of the team's 4-to-1 mux.
- Takes one valid/ready input flit stream and steers each flit to one of four output ports, selected by a 2-bit select.
- Each output has its own small FIFO, so a stalled output only holds up flits addressed to it.
- Sits on the router output side, ahead of the link drivers, in the minimal NoC.

Parameters:
- DATA_W, 32, flit width in bits.
- FIFO_DEPTH, 2, entries per output FIFO; power of two, >= 2.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_data  in  DATA_W  input flit.
- in_sel  in  2  destination output index 0..3.
- in_last  in  1  tail-flit marker; used only with DEMUX_PKT_LOCK_EN, ignored otherwise.
- in_valid  in  1  input flit valid.
- in_ready  out  1  input can accept.
- out_data  out  4*DATA_W  slice i = [i*DATA_W +: DATA_W] is the head flit of FIFO i.
- out_valid  out  4  bit i: FIFO i non-empty.
- out_ready  in  4  bit i: consumer i accepts.

Behaviour:
- Reset (rst_n=0, async): all FIFO pointers and counts cleared; out_valid=4'b0000; out_data all zero (storage reset); lock state IDLE. Any flits in flight are discarded.
- Route index r = in_sel; under lock (see Optional Feature) r = lock_sel.
- in_ready = !full[r]; combinational from in_sel/lock state and FIFO counts only, never from in_valid.
- Accept: in_valid && in_ready at a rising edge writes in_data into FIFO r.
- Output i: out_valid[i] = !empty[i]; out_data slice i = FIFO i head entry (registered storage, no combinational input-to-output path).
- Pop: out_valid[i] && out_ready[i] at an edge advances FIFO i read pointer.
- Latency: flit accepted at edge N is visible on out_valid/out_data at N+1 at the earliest. No bypass path.
- Push and pop on the same FIFO in the same cycle: both occur; count unchanged.
- Full FIFO: in_ready=0 even if that FIFO pops the same cycle (no pass-through when full); accept resumes the following cycle.
- Empty FIFO: pop impossible since out_valid=0; out_ready is ignored.
- Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- Throughput: one flit in per cycle and up to four out per cycle. Per-output order is preserved; no ordering between outputs.
- in_sel may change while in_valid=1 and in_ready=0; in_ready re-evaluates combinationally against the new target.

Optional Feature:
- Macro: DEMUX_PKT_LOCK_EN.
- Defined: 2-state FSM, IDLE and LOCKED, with a lock_sel register.
  - IDLE: r=in_sel. An accepted flit with in_last=0 latches lock_sel=in_sel and moves to LOCKED. An accepted flit with in_last=1 (single-flit packet) stays in IDLE.
  - LOCKED: in_sel is ignored and r=lock_sel. An accepted flit with in_last=1 returns to IDLE. Non-accepted cycles hold state.
  - Reset mid-packet forces IDLE.
  - Result: whole packets stay contiguous on a single output.
- Undefined: no FSM; in_last is ignored; every flit routes on its own in_sel.

Test Plan:
- Reset, then drive in_valid=1, in_sel=2, in_data=0xA5A5_0001 for one cycle -> next cycle out_valid=4'b0100 and slice 2 = 0xA5A5_0001; other slices stay 0.
- Fill FIFO 1 (out_ready[1]=0), sending 0x11 then 0x12 -> after 2 accepts in_ready=0 for in_sel=1 but in_ready=1 for in_sel=3. Then set out_ready[1]=1 -> 0x11 then 0x12 drain in order.
- Stream 0x20..0x27 round-robin over sel 0..3 with all out_ready=1 -> in_ready stays 1; each output sees its two flits in order, one per cycle, with 1-cycle latency.
- Same-cycle push and pop on FIFO 0 holding one entry (0x30 held, push 0x31, out_ready[0]=1) -> count stays 1 and the head becomes 0x31.
- Assert rst_n=0 asynchronously mid-cycle with 3 flits buffered -> out_valid=0 and in_ready=1 immediately, before the next clock edge.
- DEMUX_PKT_LOCK_EN: send a 3-flit packet with in_sel=0,2,3 on successive flits (in_last=0,0,1) -> all 3 flits appear on output 0. The next flit with in_sel=2 goes to output 2. Without the macro, the same stimulus lands on outputs 0, 2, 3.
